uart_tx_feeder: RTL and testbench

//   Byte FIFO plus transmit sequencer placed directly upstream of the UART core.
//   It accepts bursts of bytes from the system side and drains them one at a time into the

---
 rtl/uart_tx_feeder_pkg.sv | 11 +
 rtl/uart_tx_feeder_if.sv | 31 +++
 rtl/uart_sync_fifo.sv | 69 ++++++
 rtl/uart_tx_feeder.sv | 73 +++++++
 tb/tb_uart_tx_feeder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// Shared UART constants: data width and the transmit sequencer state encoding.
// Also used by the UART core so both sides agree on the byte width.
package uart_tx_feeder_pkg;

   localparam int UART_DW = 8;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LAUNCH = 2'd1;
   localparam logic [1:0] WAIT   = 2'd2;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// System-side write port and UART transmit handshake of the byte feeder.
// The slave modport is the feeder; the master modport is its environment.
interface uart_tx_feeder_if
   import uart_tx_feeder_pkg::*;
#(
   parameter int AW = 4
);

   logic               wr_en;
   logic [UART_DW-1:0] wr_data;
   logic               full;
   logic               empty;
   logic [AW:0]        count;
   logic               overflow;
   logic [UART_DW-1:0] txdata;
   logic               txstart;
   logic               txbusy;
   logic               txdone;
   logic               active;

   modport slave (
      input  wr_en, wr_data, txbusy, txdone,
      output full, empty, count, overflow, txdata, txstart, active
   );

   modport master (
      output wr_en, wr_data, txbusy, txdone,
      input  full, empty, count, overflow, txdata, txstart, active
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered status flags and occupancy count.
// The head entry is read straight out of the flop storage array.
module uart_sync_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr,
   input  logic [DW-1:0] wdata,
   input  logic          rd,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow
);

   localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_wr;
   logic          do_rd;
   logic [AW:0]   count_nxt;

   // Acceptance uses the registered FULL only, so a same-cycle pop never frees a slot.
   assign do_wr = wr && !full;
   assign do_rd = rd && !empty;
   assign rdata = mem[rptr];

   always_comb begin
      count_nxt = count;
      if (do_wr && !do_rd)
         count_nxt = count + CNT_ONE;
      else if (!do_wr && do_rd)
         count_nxt = count - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (do_wr)
            wptr <= wptr + PTR_ONE;
         if (do_rd)
            rptr <= rptr + PTR_ONE;
         count    <= count_nxt;
         full     <= (count_nxt == FULL_CNT);
         empty    <= (count_nxt == '0);
         overflow <= wr && full;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wptr] <= wdata;
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus transmit sequencer feeding the UART core one byte at a time
// through the TXDATA/TXSTART/TXBUSY/TXDONE handshake.
module uart_tx_feeder
   import uart_tx_feeder_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              rst,
   uart_tx_feeder_if.slave   bus
);

   logic [1:0]         state;
   logic               pop;
   logic [UART_DW-1:0] head;

   // Launch only from IDLE; TXBUSY is ignored once a byte is in flight.
   assign pop = (state == IDLE) && !bus.empty && !bus.txbusy;

   uart_sync_fifo #(
      .DW    (UART_DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr       (bus.wr_en),
      .wdata    (bus.wr_data),
      .rd       (pop),
      .rdata    (head),
      .full     (bus.full),
      .empty    (bus.empty),
      .count    (bus.count),
      .overflow (bus.overflow)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bus.txdata  <= '0;
         bus.txstart <= 1'b0;
         bus.active  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  bus.txdata  <= head;
                  bus.txstart <= 1'b1;
                  bus.active  <= 1'b1;
                  state       <= LAUNCH;
               end
            end
            LAUNCH: begin
               bus.txstart <= 1'b0;
               state       <= WAIT;
            end
            WAIT: begin
               if (bus.txdone) begin
                  bus.active <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               bus.txstart <= 1'b0;
               bus.active  <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a per-cycle vector table plus multi-cycle
// sequences against a small behavioural UART that records every launched byte.
`timescale 1ns/1ps
module tb_uart_tx_feeder;
   import uart_tx_feeder_pkg::*;

   localparam int FRAME = 12;
   localparam int NVEC  = 14;

   typedef struct packed {
      logic        wr;
      logic [7:0]  d;
      logic        busy;
      logic        done;
      logic [17:0] exp;   // {full, empty, count[4:0], overflow, txstart, active, txdata}
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_feeder_if #(.AW(4)) bus ();

   uart_tx_feeder #(.DEPTH(16), .AW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic       uart_en, hold_busy, vec_done, ubusy, udone;
   int         ucnt;
   logic [7:0] line_q [$];
   logic [7:0] exp_q  [$];
   int         vectors = 0;
   int         miscompares = 0;
   vec_t       tbl [NVEC];

   assign bus.txbusy = ubusy | hold_busy;
   assign bus.txdone = udone | vec_done;

   // Behavioural UART: latch the byte on TXSTART, stay busy FRAME cycles, pulse TXDONE.
   always @(posedge clk) begin
      udone <= 1'b0;
      if (rst) begin
         ubusy <= 1'b0;
         ucnt  <= 0;
      end else if (uart_en && bus.txstart) begin
         ubusy <= 1'b1;
         ucnt  <= FRAME;
         line_q.push_back(bus.txdata);
      end else if (ucnt != 0) begin
         ucnt <= ucnt - 1;
         if (ucnt == 1) begin
            udone <= 1'b1;
            ubusy <= 1'b0;
         end
      end
   end

   function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic busy,
                               input logic done, input logic full, input logic empty,
                               input logic [4:0] cnt, input logic ovf, input logic start,
                               input logic act, input logic [7:0] txd);
      vec_t v;
      v.wr = wr; v.d = d; v.busy = busy; v.done = done;
      v.exp = {full, empty, cnt, ovf, start, act, txd};
      return v;
   endfunction

   function automatic logic [17:0] obs();
      return {bus.full, bus.empty, bus.count, bus.overflow, bus.txstart, bus.active, bus.txdata};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; bus.wr_en = 1'b0; hold_busy = 1'b0; vec_done = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_drain(input int n, input int limit, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < limit; c++) begin
         @(negedge clk);
         if (line_q.size() == n && !bus.active && bus.empty) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int sent;
      //               wr  d      bsy dn  full emp cnt ovf st act txd
      tbl[0]  = mk(1, 8'h11, 1, 0,  0,  0,  1, 0, 0, 0, 8'h00);
      tbl[1]  = mk(1, 8'h22, 1, 0,  0,  0,  2, 0, 0, 0, 8'h00);
      tbl[2]  = mk(0, 8'h00, 1, 0,  0,  0,  2, 0, 0, 0, 8'h00);
      tbl[3]  = mk(0, 8'h00, 0, 0,  0,  0,  1, 0, 1, 1, 8'h11);
      tbl[4]  = mk(0, 8'h00, 0, 0,  0,  0,  1, 0, 0, 1, 8'h11);
      tbl[5]  = mk(1, 8'h33, 0, 0,  0,  0,  2, 0, 0, 1, 8'h11);
      tbl[6]  = mk(0, 8'h00, 1, 0,  0,  0,  2, 0, 0, 1, 8'h11);
      tbl[7]  = mk(0, 8'h00, 0, 1,  0,  0,  2, 0, 0, 0, 8'h11);
      tbl[8]  = mk(0, 8'h00, 0, 0,  0,  0,  1, 0, 1, 1, 8'h22);
      tbl[9]  = mk(0, 8'h00, 0, 1,  0,  0,  1, 0, 0, 1, 8'h22);
      tbl[10] = mk(0, 8'h00, 0, 0,  0,  0,  1, 0, 0, 1, 8'h22);
      tbl[11] = mk(0, 8'h00, 0, 1,  0,  0,  1, 0, 0, 0, 8'h22);
      tbl[12] = mk(0, 8'h00, 1, 1,  0,  0,  1, 0, 0, 0, 8'h22);
      tbl[13] = mk(1, 8'h44, 0, 0,  0,  0,  1, 0, 1, 1, 8'h33);

      rst = 1'b1; uart_en = 1'b0; hold_busy = 1'b0; vec_done = 1'b0;
      bus.wr_en = 1'b0; bus.wr_data = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_state", 32'(obs()), 32'({1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00}));

      // Per-cycle table: latency, busy stall, TXDONE outside WAIT, write+pop same cycle.
      for (int i = 0; i < NVEC; i++) begin
         bus.wr_en = tbl[i].wr; bus.wr_data = tbl[i].d;
         hold_busy = tbl[i].busy; vec_done = tbl[i].done;
         @(negedge clk);
         check($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
      end

      // Single byte end to end with the UART model answering.
      do_reset();
      uart_en = 1'b1; line_q.delete();
      bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
      @(negedge clk);
      check("a5_no_start_yet", bus.txstart, 0);
      check("a5_count1", bus.count, 1);
      bus.wr_en = 1'b0;
      @(negedge clk);
      check("a5_start", bus.txstart, 1);
      check("a5_txdata", bus.txdata, 8'hA5);
      wait_drain(1, 100, ok);
      check("a5_drain", ok, 1);
      if (ok) check("a5_line", line_q[0], 8'hA5);

      // Fill to full with the UART busy, overflow, then full+pop+write in one cycle.
      do_reset();
      uart_en = 1'b1; hold_busy = 1'b1; line_q.delete();
      for (int i = 0; i < 16; i++) begin
         bus.wr_en = 1'b1; bus.wr_data = 8'(i);
         @(negedge clk);
      end
      check("burst_full", bus.full, 1);
      check("burst_count16", bus.count, 16);
      bus.wr_data = 8'hFF;
      @(negedge clk);
      check("ovf_pulse", bus.overflow, 1);
      check("ovf_count16", bus.count, 16);
      hold_busy = 1'b0; bus.wr_data = 8'hEE;
      @(negedge clk);
      check("fullpop_count15", bus.count, 15);
      check("fullpop_ovf", bus.overflow, 1);
      check("fullpop_start", bus.txstart, 1);
      check("fullpop_txdata", bus.txdata, 8'h00);
      bus.wr_en = 1'b0;
      @(negedge clk);
      check("ovf_cleared", bus.overflow, 0);
      check("count15_hold", bus.count, 15);
      wait_drain(16, 16 * (FRAME + 6) + 50, ok);
      check("burst_drain", ok, 1);
      check("burst_line_len", line_q.size(), 16);
      for (int i = 0; i < 16 && i < line_q.size(); i++)
         check($sformatf("burst_byte%0d", i), line_q[i], 8'(i));

      // Reset while a byte is in flight with five more queued.
      do_reset();
      uart_en = 1'b1; line_q.delete();
      for (int i = 0; i < 6; i++) begin
         bus.wr_en = 1'b1; bus.wr_data = 8'(8'h50 + i);
         @(negedge clk);
      end
      bus.wr_en = 1'b0;
      @(negedge clk);
      check("pre_rst_count5", bus.count, 5);
      check("pre_rst_active", bus.active, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_count0", bus.count, 0);
      check("rst_empty", bus.empty, 1);
      check("rst_active0", bus.active, 0);
      check("rst_txstart0", bus.txstart, 0);
      rst = 1'b0; line_q.delete();
      repeat (40) @(negedge clk);
      check("post_rst_no_start", line_q.size(), 0);
      check("post_rst_empty", bus.empty, 1);

      // 40 random bytes streamed through, wrapping the pointers.
      do_reset();
      uart_en = 1'b1; line_q.delete(); exp_q.delete();
      sent = 0;
      for (int c = 0; c < 2000 && sent < 40; c++) begin
         if (!bus.full) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'($urandom_range(0, 255));
            exp_q.push_back(bus.wr_data);
            sent++;
         end else begin
            bus.wr_en = 1'b0;
         end
         @(negedge clk);
      end
      bus.wr_en = 1'b0;
      check("stream_sent", sent, 40);
      wait_drain(40, 40 * (FRAME + 6) + 100, ok);
      check("stream_drain", ok, 1);
      check("stream_len", line_q.size(), 40);
      for (int i = 0; i < 40 && i < line_q.size(); i++)
         check($sformatf("stream_byte%0d", i), line_q[i], exp_q[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
